fetch_unit: RTL and testbench
=============================

# fetch_unit

Sequential fetch stage for the pipelined Y86-64 core. Drives the byte-wide instruction memory and selects the next PC from three sources: the predicted PC, a mispredicted branch in M, or a `ret` in W. Assembles the 1–10 instruction bytes and presents one decoded fetch record per valid/ready handshake to the D pipeline register. Replaces the combinational fetch/f_reg/pc_update path with a registered, stallable front end.

## Interface
- RESET_PC, 64'd0, PC fetched first after reset
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- imem_rd  out  1  read strobe
- imem_addr  out  64  byte address
- imem_rdata  in  8  byte; valid the cycle after imem_rd
- imem_err  in  1  address error; same timing as imem_rdata
- redir_m  in  1  mispredicted jXX in M
- redir_m_pc  in  64  M valA (fall-through)
- redir_w  in  1  ret in W
- redir_w_pc  in  64  W valM
- f_ready  in  1  D register accepts
- f_valid  out  1  fetch record valid
- f_stat  out  3  AOK=1, HLT=2, ADR=3, INS=4
- f_icode, f_ifun, f_rA, f_rB  out  4 each  decoded fields
- f_valC  out  64  constant, little-endian
- f_valP  out  64  PC + length
- pred_pc  out  64  predicted next PC

## Operation
- States: START, BYTE0, COLLECT, HOLD, STOP.
- START: imem_rd=0. Goes to BYTE0 on the next edge.
- BYTE0:
  - imem_rd=1, imem_addr=pc. Goes to COLLECT.
- COLLECT:
  - Captures the returned byte.
  - In the first COLLECT cycle, byte0 gives icode/ifun, and the length L is decoded combinationally.
  - Issues address pc+k while k<L, one byte per cycle.
  - After byte L-1 is captured, goes to HOLD.
- Instruction lengths:
  - halt, nop, ret: 1
  - rrmovq/cmovXX, OPq, pushq, popq: 2
  - jXX, call: 9
  - irmovq, rmmovq, mrmovq: 10
  - icode>0xB: INS, length 1
- Field layout:
  - Register byte (byte 1, when present): rA=[7:4], rB=[3:0].
  - Without a register byte: rA=rB=0xF.
  - valC comes from bytes 1–8 (jXX/call) or bytes 2–9; otherwise 0.
- f_valP = pc+L, modulo 2^64 (wrap allowed).
- pred_pc = valC for jXX and call, otherwise valP.
- HOLD:
  - f_valid=1; all f_* outputs stable; imem_rd=0.
  - On f_valid&&f_ready: pc←pred_pc and go to BYTE0, except when f_stat≠AOK, which goes to STOP.
- STOP: imem_rd=0, f_valid=0. Leaves only on redirect.
- imem_err on any byte: abort the remaining reads, go to HOLD with f_stat=ADR and the fields captured so far.
- Redirect (any state):
  - Priority is redir_m over redir_w.
  - pc←selected target; go to BYTE0 next cycle.
  - Drop any in-flight byte; next-cycle f_valid=0.
  - If it coincides with a HOLD handshake, the handshake completes and the redirect target wins over pred_pc.
- Reset mid-operation: immediate abort, all state discarded.

## Timing
- Reset values:
  - state=START, pc=RESET_PC
  - imem_rd=0, imem_addr=0, f_valid=0, f_stat=AOK
  - f_icode=f_ifun=0, f_rA=f_rB=0xF
  - f_valC=f_valP=pred_pc=0
- With BYTE0 at cycle t0:
  - byte k is addressed at t0+k and returned at t0+k+1.
  - f_valid rises at t0+L+1.
- Handshake at cycle h → BYTE0 at h+1.
- Throughput: one instruction per L+2 cycles with f_ready held high.
- Redirect asserted at cycle r → imem_addr = target at r+1.

## Structure
- Shared package y86_pkg:
  - icode constants (HALT…POPQ)
  - stat codes
  - register code RNONE=0xF
- Sub-module fetch_len_dec (combinational):
  - Input: icode.
  - Outputs: length, need_regids, need_valC, instr_valid.
- fetch_unit holds the FSM, the byte counter, pc, and the assembly registers.

## Test plan
- RESET_PC=0x1F, mem[0x1F]=0x10 (nop), f_ready=1:
  - imem_addr=0x1F one cycle after reset release.
  - f_valid at t0+2 with icode=1, f_valP=pred_pc=0x20, stat=AOK.
- irmovq at 0, bytes 30 F0 EF CD AB 89 67 45 23 01:
  - rA=F, rB=0, valC=0x0123456789ABCDEF, valP=10.
  - f_valid at t0+11.
- Same instruction with f_ready=0 for 5 cycles:
  - All f_* stable, imem_rd=0.
  - Release → next imem_addr=10.
- jXX 70 40 00..00 at 0:
  - pred_pc=0x40; next fetch at 0x40.
  - redir_m=1, redir_m_pc=0x9 during COLLECT → next imem_addr=0x9, no f_valid for the aborted fetch.
- redir_m (0x100) and redir_w (0x200) in the same cycle → next imem_addr=0x100.
- Terminating cases, each followed by imem_rd=0 until a redirect:
  - byte 0x00 → stat HLT, valP=pc+1.
  - byte 0xC0 → stat INS.
  - imem_err on byte 3 of an rmmovq → stat ADR.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, register
// encodings and the fetch FSM state type.
package y86_pkg;

  // Instruction codes (upper nibble of byte 0)
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Status codes carried with each fetch record
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // "No register" encoding used when an instruction has no register byte
  localparam logic [3:0] RNONE = 4'hF;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_BYTE0   = 3'd1,
    S_COLLECT = 3'd2,
    S_HOLD    = 3'd3,
    S_STOP    = 3'd4
  } fetch_state_e;

  // Control transfers whose predicted target is the constant word
  function automatic logic is_jump(input logic [3:0] icode);
    return (icode == I_JXX) || (icode == I_CALL);
  endfunction

endpackage

// File: rtl/fetch_len_dec.sv
// Combinational instruction-length decoder: from the icode nibble, derive
// the byte length and which optional fields the instruction carries.
module fetch_len_dec
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] length,
  output logic       need_regids,
  output logic       need_valC,
  output logic       instr_valid
);

  // Length and field-presence lookup; unknown icodes are one-byte INS
  always_comb begin
    length      = 4'd1;
    need_regids = 1'b0;
    need_valC   = 1'b0;
    instr_valid = 1'b1;
    case (icode)
      I_HALT, I_NOP, I_RET: begin
        length = 4'd1;
      end
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
        length      = 4'd2;
        need_regids = 1'b1;
      end
      I_JXX, I_CALL: begin
        length    = 4'd9;
        need_valC = 1'b1;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        length      = 4'd10;
        need_regids = 1'b1;
        need_valC   = 1'b1;
      end
      default: begin
        length      = 4'd1;
        instr_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Registered, stallable Y86-64 fetch stage. Reads the byte-wide instruction
// memory one byte per cycle, assembles a fetch record and holds it until the
// D register accepts it. Branch-mispredict (M) and ret (W) redirects abort
// any fetch in progress.
module fetch_unit
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_rd,
  output logic [63:0] imem_addr,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_err,
  input  logic        redir_m,
  input  logic [63:0] redir_m_pc,
  input  logic        redir_w,
  input  logic [63:0] redir_w_pc,
  input  logic        f_ready,
  output logic        f_valid,
  output logic [2:0]  f_stat,
  output logic [3:0]  f_icode,
  output logic [3:0]  f_ifun,
  output logic [3:0]  f_rA,
  output logic [3:0]  f_rB,
  output logic [63:0] f_valC,
  output logic [63:0] f_valP,
  output logic [63:0] pred_pc
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [3:0]   cnt_q, cnt_d;      // index of the byte returned this cycle
  logic [3:0]   icode_q, icode_d;
  logic [3:0]   ifun_q, ifun_d;
  logic [3:0]   ra_q, ra_d;
  logic [3:0]   rb_q, rb_d;
  logic [63:0]  valc_q, valc_d;
  logic [63:0]  valp_q, valp_d;
  logic [63:0]  pred_q, pred_d;
  logic [2:0]   stat_q, stat_d;

  logic         first_s;
  logic [3:0]   dec_icode_s;
  logic [3:0]   len_s;
  logic         need_regids_s;
  logic         need_valc_s;
  logic         instr_valid_s;
  logic [3:0]   valc_off_s;
  logic         last_s;
  logic         redir_s;
  logic [63:0]  redir_pc_s;
  logic         hs_s;

  // Byte 0 is decoded straight off the memory bus in the first COLLECT
  // cycle; afterwards the captured icode drives the decoder.
  assign first_s     = (state_q == S_COLLECT) && (cnt_q == 4'd0);
  assign dec_icode_s = first_s ? imem_rdata[7:4] : icode_q;

  fetch_len_dec u_len_dec (
    .icode       (dec_icode_s),
    .length      (len_s),
    .need_regids (need_regids_s),
    .need_valC   (need_valc_s),
    .instr_valid (instr_valid_s)
  );

  assign valc_off_s = need_regids_s ? 4'd2 : 4'd1;
  assign last_s     = ((cnt_q + 4'd1) >= len_s);
  assign redir_s    = redir_m | redir_w;
  assign redir_pc_s = redir_m ? redir_m_pc : redir_w_pc;
  assign hs_s       = (state_q == S_HOLD) && f_ready;

  assign f_valid = (state_q == S_HOLD);
  assign f_stat  = stat_q;
  assign f_icode = icode_q;
  assign f_ifun  = ifun_q;
  assign f_rA    = ra_q;
  assign f_rB    = rb_q;
  assign f_valC  = valc_q;
  assign f_valP  = valp_q;
  assign pred_pc = pred_q;

  // Memory request: byte 0 in BYTE0, then pc+k while more bytes are needed;
  // an error or redirect stops further reads immediately.
  always_comb begin
    imem_rd   = 1'b0;
    imem_addr = 64'd0;
    case (state_q)
      S_BYTE0: begin
        imem_rd   = 1'b1;
        imem_addr = pc_q;
      end
      S_COLLECT: begin
        if (!last_s && !imem_err && !redir_s) begin
          imem_rd   = 1'b1;
          imem_addr = pc_q + {60'd0, cnt_q + 4'd1};
        end else begin
          imem_rd   = 1'b0;
          imem_addr = 64'd0;
        end
      end
      default: begin
        imem_rd   = 1'b0;
        imem_addr = 64'd0;
      end
    endcase
  end

  // Next-state logic: sequencing, byte assembly, PC selection, redirects
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    pred_d  = pred_q;
    stat_d  = stat_q;

    case (state_q)
      S_START: begin
        state_d = S_BYTE0;
      end

      S_BYTE0: begin
        state_d = S_COLLECT;
        cnt_d   = 4'd0;
        icode_d = I_HALT;
        ifun_d  = 4'd0;
        ra_d    = RNONE;
        rb_d    = RNONE;
        valc_d  = 64'd0;
        stat_d  = STAT_AOK;
      end

      S_COLLECT: begin
        if (imem_err) begin
          // Keep what was captured so far and report an address error
          stat_d  = STAT_ADR;
          valp_d  = pc_q + {60'd0, len_s};
          pred_d  = pc_q + {60'd0, len_s};
          state_d = S_HOLD;
        end else begin
          if (first_s) begin
            icode_d = imem_rdata[7:4];
            ifun_d  = imem_rdata[3:0];
            if (!instr_valid_s) begin
              stat_d = STAT_INS;
            end else if (imem_rdata[7:4] == I_HALT) begin
              stat_d = STAT_HLT;
            end else begin
              stat_d = STAT_AOK;
            end
          end else if (need_regids_s && (cnt_q == 4'd1)) begin
            ra_d = imem_rdata[7:4];
            rb_d = imem_rdata[3:0];
          end else if (need_valc_s && (cnt_q >= valc_off_s)) begin
            // Little-endian: each new byte enters at the top and shifts down
            valc_d = {imem_rdata, valc_q[63:8]};
          end else begin
            valc_d = valc_q;
          end

          if (last_s) begin
            state_d = S_HOLD;
            valp_d  = pc_q + {60'd0, len_s};
            pred_d  = is_jump(dec_icode_s) ? valc_d : (pc_q + {60'd0, len_s});
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      S_HOLD: begin
        if (hs_s) begin
          if (stat_q != STAT_AOK) begin
            state_d = S_STOP;
          end else begin
            state_d = S_BYTE0;
            pc_d    = pred_q;
          end
        end else begin
          state_d = S_HOLD;
        end
      end

      S_STOP: begin
        state_d = S_STOP;
      end

      default: begin
        state_d = S_START;
      end
    endcase

    // A redirect wins over everything, including a completing handshake;
    // the in-flight byte is discarded and the record left untouched.
    if (redir_s) begin
      state_d = S_BYTE0;
      pc_d    = redir_pc_s;
      cnt_d   = cnt_q;
      icode_d = icode_q;
      ifun_d  = ifun_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      valc_d  = valc_q;
      valp_d  = valp_q;
      pred_d  = pred_q;
      stat_d  = stat_q;
    end else begin
      state_d = state_d;
    end
  end

  // State, PC and fetch-record registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_START;
      pc_q    <= RESET_PC;
      cnt_q   <= 4'd0;
      icode_q <= 4'd0;
      ifun_q  <= 4'd0;
      ra_q    <= RNONE;
      rb_q    <= RNONE;
      valc_q  <= 64'd0;
      valp_q  <= 64'd0;
      pred_q  <= 64'd0;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      pred_q  <= pred_d;
      stat_q  <= stat_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a byte-wide memory model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_rd;
  logic [63:0] imem_addr;
  logic [7:0]  imem_rdata;
  logic        imem_err;
  logic        redir_m;
  logic [63:0] redir_m_pc;
  logic        redir_w;
  logic [63:0] redir_w_pc;
  logic        f_ready;
  logic        f_valid;
  logic [2:0]  f_stat;
  logic [3:0]  f_icode;
  logic [3:0]  f_ifun;
  logic [3:0]  f_rA;
  logic [3:0]  f_rB;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic [63:0] pred_pc;

  int checks;
  int failures;

  logic [7:0]  mem [0:1023];
  logic [63:0] err_addr;

  fetch_unit #(.RESET_PC(64'h1F)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_err   (imem_err),
    .redir_m    (redir_m),
    .redir_m_pc (redir_m_pc),
    .redir_w    (redir_w),
    .redir_w_pc (redir_w_pc),
    .f_ready    (f_ready),
    .f_valid    (f_valid),
    .f_stat     (f_stat),
    .f_icode    (f_icode),
    .f_ifun     (f_ifun),
    .f_rA       (f_rA),
    .f_rB       (f_rB),
    .f_valC     (f_valC),
    .f_valP     (f_valP),
    .pred_pc    (pred_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data and error appear the cycle after the read strobe
  always @(posedge clk) begin
    if (imem_rd) begin
      imem_rdata <= mem[imem_addr[9:0]];
      imem_err   <= (imem_addr == err_addr);
    end else begin
      imem_rdata <= 8'h00;
      imem_err   <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h10;
    // irmovq $0x0123456789ABCDEF, %rax at 0
    mem[0] = 8'h30; mem[1] = 8'hF0; mem[2] = 8'hEF; mem[3] = 8'hCD; mem[4] = 8'hAB;
    mem[5] = 8'h89; mem[6] = 8'h67; mem[7] = 8'h45; mem[8] = 8'h23; mem[9] = 8'h01;
    // rmmovq at 10; byte 3 (address 13) faults
    mem[10] = 8'h40; mem[11] = 8'h12; mem[12] = 8'h11;
    err_addr = 64'd13;
    mem[8'h1F] = 8'h10;               // nop
    mem[8'h20] = 8'h00;               // halt
    mem[8'h40] = 8'h30;               // irmovq (aborted by redirect)
    mem[8'h80] = 8'h70; mem[8'h81] = 8'h40;
    for (int i = 8'h82; i <= 8'h88; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'hC0;             // invalid icode
    mem[10'h200] = 8'h10;             // nop

    rst_n = 1'b0; f_ready = 1'b1;
    redir_m = 1'b0; redir_m_pc = 64'd0; redir_w = 1'b0; redir_w_pc = 64'd0;
    tick(); tick();
    chk("rst_rd", imem_rd, 1'b0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_valid", f_valid, 1'b0);
    chk("rst_stat", f_stat, 3'd1);
    chk("rst_icode", f_icode, 4'd0);
    chk("rst_ifun", f_ifun, 4'd0);
    chk("rst_rA", f_rA, 4'hF);
    chk("rst_rB", f_rB, 4'hF);
    chk("rst_valC", f_valC, 64'd0);
    chk("rst_valP", f_valP, 64'd0);
    chk("rst_pred", pred_pc, 64'd0);
    rst_n = 1'b1;

    // nop at 0x1F
    tick();
    chk("nop_rd", imem_rd, 1'b1);
    chk("nop_addr", imem_addr, 64'h1F);
    tick();
    chk("nop_valid_early", f_valid, 1'b0);
    tick();
    chk("nop_valid", f_valid, 1'b1);
    chk("nop_icode", f_icode, 4'h1);
    chk("nop_valP", f_valP, 64'h20);
    chk("nop_pred", pred_pc, 64'h20);
    chk("nop_stat", f_stat, 3'd1);
    // halt at 0x20, fetched right after the handshake
    tick();
    chk("halt_rd", imem_rd, 1'b1);
    chk("halt_addr", imem_addr, 64'h20);
    tick();
    chk("halt_no_more_rd", imem_rd, 1'b0);
    tick();
    chk("halt_valid", f_valid, 1'b1);
    chk("halt_stat", f_stat, 3'd2);
    chk("halt_valP", f_valP, 64'h21);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_stop_rd", imem_rd, 1'b0);
      chk("halt_stop_valid", f_valid, 1'b0);
    end

    // irmovq at 0 held for 5 cycles
    redir_m = 1'b1; redir_m_pc = 64'd0; f_ready = 1'b0;
    tick();
    chk("irm_addr", imem_addr, 64'd0);
    chk("irm_rd", imem_rd, 1'b1);
    redir_m = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("irm_valid_early", f_valid, 1'b0);
    tick();
    chk("irm_valid", f_valid, 1'b1);
    chk("irm_icode", f_icode, 4'h3);
    chk("irm_rA", f_rA, 4'hF);
    chk("irm_rB", f_rB, 4'h0);
    chk("irm_valC", f_valC, 64'h0123456789ABCDEF);
    chk("irm_valP", f_valP, 64'd10);
    chk("irm_pred", pred_pc, 64'd10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", f_valid, 1'b1);
      chk("stall_rd", imem_rd, 1'b0);
      chk("stall_valC", f_valC, 64'h0123456789ABCDEF);
      chk("stall_rB", f_rB, 4'h0);
    end
    f_ready = 1'b1;
    tick();
    chk("release_addr", imem_addr, 64'd10);
    chk("release_rd", imem_rd, 1'b1);

    // rmmovq at 10 with error on byte 3
    tick(); tick(); tick();
    chk("adr_byte3_addr", imem_addr, 64'd13);
    tick();
    chk("adr_abort_rd", imem_rd, 1'b0);
    tick();
    chk("adr_valid", f_valid, 1'b1);
    chk("adr_stat", f_stat, 3'd3);
    chk("adr_icode", f_icode, 4'h4);
    chk("adr_rA", f_rA, 4'h1);
    chk("adr_rB", f_rB, 4'h2);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("adr_stop_rd", imem_rd, 1'b0);
      chk("adr_stop_valid", f_valid, 1'b0);
    end

    // jXX at 0x80 predicting 0x40
    redir_m = 1'b1; redir_m_pc = 64'h80;
    tick();
    chk("jxx_addr", imem_addr, 64'h80);
    redir_m = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("jxx_valid_early", f_valid, 1'b0);
    tick();
    chk("jxx_valid", f_valid, 1'b1);
    chk("jxx_icode", f_icode, 4'h7);
    chk("jxx_rA", f_rA, 4'hF);
    chk("jxx_valC", f_valC, 64'h40);
    chk("jxx_valP", f_valP, 64'h89);
    chk("jxx_pred", pred_pc, 64'h40);
    tick();
    chk("jxx_target_addr", imem_addr, 64'h40);
    // Mispredict redirect during COLLECT of the irmovq at 0x40
    tick(); tick();
    redir_m = 1'b1; redir_m_pc = 64'h9;
    tick();
    chk("mis_addr", imem_addr, 64'h9);
    chk("mis_rd", imem_rd, 1'b1);
    chk("mis_valid", f_valid, 1'b0);
    redir_m = 1'b0;
    tick();
    chk("mis_valid2", f_valid, 1'b0);
    tick();
    chk("mis_new_valid", f_valid, 1'b1);
    chk("mis_new_stat", f_stat, 3'd2);
    chk("mis_new_valP", f_valP, 64'hA);
    tick();

    // Simultaneous M and W redirects: M wins
    redir_m = 1'b1; redir_m_pc = 64'h100; redir_w = 1'b1; redir_w_pc = 64'h200;
    tick();
    chk("prio_addr", imem_addr, 64'h100);
    redir_m = 1'b0; redir_w = 1'b0;
    tick(); tick();
    chk("ins_valid", f_valid, 1'b1);
    chk("ins_stat", f_stat, 3'd4);
    chk("ins_icode", f_icode, 4'hC);
    chk("ins_valP", f_valP, 64'h101);
    tick(); tick();
    chk("ins_stop_rd", imem_rd, 1'b0);

    // W redirect alone, then redirect coinciding with a HOLD handshake
    redir_w = 1'b1; redir_w_pc = 64'h200;
    tick();
    chk("ret_addr", imem_addr, 64'h200);
    redir_w = 1'b0;
    tick(); tick();
    chk("hsr_valid", f_valid, 1'b1);
    chk("hsr_valP", f_valP, 64'h201);
    redir_m = 1'b1; redir_m_pc = 64'h80;
    tick();
    chk("hsr_addr", imem_addr, 64'h80);
    chk("hsr_valid_drop", f_valid, 1'b0);
    redir_m = 1'b0;

    // Asynchronous reset mid-fetch
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_rd", imem_rd, 1'b0);
    chk("arst_addr", imem_addr, 64'd0);
    chk("arst_valid", f_valid, 1'b0);
    chk("arst_icode", f_icode, 4'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_restart_addr", imem_addr, 64'h1F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
